// File: rtl/mssd_pkg.sv
// Shared types and width helpers for the parametrised serial message demultiplexer.
package mssd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        PARITY,
        STOP,
        ERROR
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;

    function automatic int port_bits(input int num_ports);
        return $clog2(num_ports);
    endfunction

    // Wide enough for the longest payload, so the bit counter can never wrap.
    function automatic int count_bits(input int len_bits, input int unit_bits);
        return $clog2((2 ** len_bits - 1) * unit_bits + 1);
    endfunction

endpackage

// File: rtl/mssd_down_counter.sv
// Loadable down-counter; tc flags the last counted cycle (count == 1).
module mssd_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == WIDTH'(1));

endmodule

// File: rtl/mssd_demux_param.sv
// Serial message demultiplexer: decodes framed messages and routes payload bits to the addressed channel.
//   state  | meaning
//   IDLE   | line idle, waiting for a start bit (0)
//   HEADER | shifting in length field then port field, MSB first
//   DATA   | payload bits routed to P[pn], parity accumulated
//   PARITY | even-parity bit compared with accumulated payload parity
//   STOP   | expecting stop bit (1)
//   ERROR  | bad stop bit seen, waiting for line to return high
module mssd_demux_param
    import mssd_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int LEN_BITS  = 6,
    parameter  int UNIT_BITS = 8,
    parameter  int PARITY_EN = PARITY_EVEN,
    localparam int PORT_BITS = port_bits(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serIn,
    output logic [NUM_PORTS-1:0] P,
    output logic [PORT_BITS-1:0] pn,
    output logic                 outValid,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic                 error
);

    localparam int HDR_BITS = LEN_BITS + PORT_BITS;
    localparam int HCW      = $clog2(HDR_BITS + 1);
    localparam int CW       = count_bits(LEN_BITS, UNIT_BITS);

    state_t              state;
    logic [HDR_BITS-2:0] hdr_sr;
    logic [HDR_BITS-1:0] hdr_full;
    logic [LEN_BITS-1:0] hdr_len;
    logic [PORT_BITS-1:0] hdr_port;
    logic [CW-1:0]       pay_len;
    logic                acc;
    logic                par_flag;
    logic                hdr_load;
    logic                hdr_tc;
    logic                dat_load;
    logic                dat_tc;

    // The current line bit completes the header on its last cycle.
    assign hdr_full = {hdr_sr, serIn};
    assign hdr_len  = hdr_full[HDR_BITS-1:PORT_BITS];
    assign hdr_port = hdr_full[PORT_BITS-1:0];
    assign pay_len  = CW'(hdr_len) * CW'(UNIT_BITS);
    assign hdr_load = (state == IDLE) && !serIn;
    assign dat_load = (state == HEADER) && hdr_tc;

    mssd_down_counter #(.WIDTH(HCW)) u_hdr_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hdr_load),
        .en       (state == HEADER),
        .load_val (HCW'(HDR_BITS)),
        .tc       (hdr_tc)
    );

    mssd_down_counter #(.WIDTH(CW)) u_dat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dat_load),
        .en       (state == DATA),
        .load_val (pay_len),
        .tc       (dat_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hdr_sr     <= '0;
            acc        <= 1'b0;
            par_flag   <= 1'b0;
            pn         <= '0;
            frame_done <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!serIn) begin
                        state    <= HEADER;
                        acc      <= 1'b0;
                        par_flag <= 1'b0;
                    end
                end
                HEADER: begin
                    hdr_sr <= hdr_full[HDR_BITS-2:0];
                    if (hdr_tc) begin
                        pn <= hdr_port;
                        if (hdr_len != '0) begin
                            state <= DATA;
                        end else if (PARITY_EN != 0) begin
                            state <= PARITY;
                        end else begin
                            state <= STOP;
                        end
                    end
                end
                DATA: begin
                    acc <= acc ^ serIn;
                    if (dat_tc) begin
                        state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_flag <= serIn ^ acc;
                    state    <= STOP;
                end
                STOP: begin
                    if (serIn) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        parity_err <= par_flag;
                    end else begin
                        state <= ERROR;
                    end
                end
                ERROR: begin
                    if (serIn) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign outValid = (state == DATA);
    assign error    = (state == ERROR);

    always_comb begin
        P = '0;
        if (state == DATA) begin
            P[pn] = serIn;
        end
    end

endmodule

// File: tb/tb_mssd_demux_param.sv
// Randomised frame stimulus for two demux configurations, checked cycle by cycle against a frame-level model.
module tb_mssd_demux_param;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ser_a = 1'b1;
    logic ser_b = 1'b1;

    logic [3:0] p_a;
    logic [1:0] pn_a;
    logic       ov_a, fd_a, pe_a, er_a;
    logic [7:0] p_b;
    logic [2:0] pn_b;
    logic       ov_b, fd_b, pe_b, er_b;

    always #5 clk = ~clk;

    mssd_demux_param #(.NUM_PORTS(4), .LEN_BITS(6), .UNIT_BITS(8), .PARITY_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .serIn(ser_a), .P(p_a), .pn(pn_a), .outValid(ov_a),
        .frame_done(fd_a), .parity_err(pe_a), .error(er_a)
    );

    mssd_demux_param #(.NUM_PORTS(8), .LEN_BITS(6), .UNIT_BITS(8), .PARITY_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .serIn(ser_b), .P(p_b), .pn(pn_b), .outValid(ov_b),
        .frame_done(fd_b), .parity_err(pe_b), .error(er_b)
    );

    typedef struct {
        int         sel;
        logic [15:0] p;
        logic       ov;
        logic [3:0] pn;
        logic       fd;
        logic       pe;
        logic       er;
    } exp_t;

    exp_t q[$];
    int   sel = 0;
    int   m_pn[2];
    bit   m_err = 0;
    bit   pend_fd = 0;
    bit   pend_pe = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   ov_cnt[2];
    int   fd_cnt[2];
    int   pe_cnt[2];
    int   er_cnt[2];
    logic [15:0] hist_a = '0;

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endfunction

    // Compare process: one expected record per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] ap, apn, aov, afd, ape, aer;
        if (ov_a) begin
            ov_cnt[0]++;
            hist_a = {hist_a[14:0], p_a[2]};
        end
        if (fd_a) fd_cnt[0]++;
        if (pe_a) pe_cnt[0]++;
        if (er_a) er_cnt[0]++;
        if (ov_b) ov_cnt[1]++;
        if (fd_b) fd_cnt[1]++;
        if (pe_b) pe_cnt[1]++;
        if (er_b) er_cnt[1]++;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.sel == 0) begin
                ap = 16'(p_a); apn = 16'(pn_a); aov = 16'(ov_a);
                afd = 16'(fd_a); ape = 16'(pe_a); aer = 16'(er_a);
            end else begin
                ap = 16'(p_b); apn = 16'(pn_b); aov = 16'(ov_b);
                afd = 16'(fd_b); ape = 16'(pe_b); aer = 16'(er_b);
            end
            chk("P", ap, e.p);
            chk("pn", apn, 16'(e.pn));
            chk("outValid", aov, 16'(e.ov));
            chk("frame_done", afd, 16'(e.fd));
            chk("parity_err", ape, 16'(e.pe));
            chk("error", aer, 16'(e.er));
        end
    end

    task automatic put(input bit b, input bit ov);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel == 0) ser_a = b; else ser_b = b;
        e.sel = sel;
        e.ov  = ov;
        e.p   = ov ? (16'(b) << m_pn[sel]) : 16'h0;
        e.pn  = 4'(m_pn[sel]);
        e.fd  = pend_fd;
        e.pe  = pend_pe;
        e.er  = m_err;
        pend_fd = 0;
        pend_pe = 0;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b1, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Sends one frame; rst_at >= 0 pulses reset in that payload cycle and abandons the frame.
    task automatic send_frame(input int len, input int port, input bit use_fix, input logic [15:0] fix,
                              input bit flip, input bit stop_b, input int rst_at);
        int pb, pe, hb, n;
        logic [15:0] hdr;
        bit par, b;
        exp_t e;
        pb  = (sel == 0) ? 2 : 3;
        pe  = (sel == 0) ? 1 : 0;
        hb  = 6 + pb;
        n   = len * 8;
        par = 0;
        hdr = 16'((len << pb) | port);
        put(1'b0, 1'b0);
        for (int i = hb - 1; i >= 0; i--) put(hdr[i], 1'b0);
        m_pn[sel] = port;
        for (int i = 0; i < n; i++) begin
            b = use_fix ? fix[n-1-i] : 1'($urandom);
            if (i == rst_at) begin
                @(posedge clk);
                #1;
                if (sel == 0) ser_a = b; else ser_b = b;
                e.sel = sel; e.p = 16'h0; e.ov = 0; e.pn = 4'h0;
                e.fd = 0; e.pe = 0; e.er = 0;
                q.push_back(e);
                #1 rst_n = 1'b0;
                m_pn[0] = 0;
                m_pn[1] = 0;
                m_err   = 0;
                pend_fd = 0;
                pend_pe = 0;
                put(1'($urandom), 1'b0);
                put(1'b1, 1'b0);
                #1 rst_n = 1'b1;
                return;
            end
            par ^= b;
            put(b, 1'b1);
        end
        if (pe != 0) put(par ^ flip, 1'b0);
        put(stop_b, 1'b0);
        if (stop_b) begin
            pend_fd = 1;
            pend_pe = (pe != 0) ? flip : 1'b0;
        end else begin
            m_err = 1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c_ov, c_fd, c_pe, c_er;
        int len, port, rst_at, nports;
        bit flip, stop_b;

        // Reset held with the line toggling, then a long idle stretch.
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) put((i == 5) ? 1'b1 : 1'($urandom), 1'b0);
        #1 rst_n = 1'b1;
        idle(20);

        // Header 000001_10, payload 10110010, correct parity.
        c_ov = ov_cnt[0]; c_fd = fd_cnt[0]; c_pe = pe_cnt[0];
        send_frame(1, 2, 1'b1, 16'h00B2, 1'b0, 1'b1, -1);
        idle(2);
        settle();
        chk("lit_ov_cycles", 16'(ov_cnt[0] - c_ov), 16'd8);
        chk("lit_done_pulses", 16'(fd_cnt[0] - c_fd), 16'd1);
        chk("lit_parity_pulses", 16'(pe_cnt[0] - c_pe), 16'd0);
        chk("lit_route_p2", 16'(hist_a[7:0]), 16'h00B2);
        chk("lit_pn", 16'(pn_a), 16'd2);

        // Same frame with a wrong parity bit.
        c_fd = fd_cnt[0]; c_pe = pe_cnt[0];
        send_frame(1, 2, 1'b1, 16'h00B2, 1'b1, 1'b1, -1);
        idle(2);
        settle();
        chk("lit_bad_par_done", 16'(fd_cnt[0] - c_fd), 16'd1);
        chk("lit_bad_par_err", 16'(pe_cnt[0] - c_pe), 16'd1);
        chk("lit_bad_par_route", 16'(hist_a[7:0]), 16'h00B2);

        // Bad stop bit, line low three more cycles, then high.
        c_fd = fd_cnt[0]; c_er = er_cnt[0];
        send_frame(1, 2, 1'b0, 16'h0, 1'b0, 1'b0, -1);
        repeat (3) put(1'b0, 1'b0);
        put(1'b1, 1'b0);
        m_err = 0;
        idle(2);
        settle();
        chk("lit_error_cycles", 16'(er_cnt[0] - c_er), 16'd4);
        chk("lit_error_no_done", 16'(fd_cnt[0] - c_fd), 16'd0);

        // Zero-length frame to port 3, then back-to-back frame to port 1.
        c_ov = ov_cnt[0]; c_fd = fd_cnt[0];
        send_frame(0, 3, 1'b0, 16'h0, 1'b0, 1'b1, -1);
        send_frame(1, 1, 1'b0, 16'h0, 1'b0, 1'b1, -1);
        idle(2);
        settle();
        chk("lit_b2b_ov_cycles", 16'(ov_cnt[0] - c_ov), 16'd8);
        chk("lit_b2b_done", 16'(fd_cnt[0] - c_fd), 16'd2);
        chk("lit_b2b_pn", 16'(pn_a), 16'd1);

        // Reset in the 4th payload cycle, then a full frame to port 0.
        send_frame(2, 1, 1'b0, 16'h0, 1'b0, 1'b1, 3);
        idle(1);
        send_frame(1, 0, 1'b0, 16'h0, 1'b0, 1'b1, -1);
        idle(2);

        // Eight-port, no-parity instance: header 000010_101.
        sel = 1;
        idle(2);
        c_ov = ov_cnt[1]; c_fd = fd_cnt[1];
        send_frame(2, 5, 1'b0, 16'h0, 1'b0, 1'b1, -1);
        idle(2);
        settle();
        chk("lit_b_ov_cycles", 16'(ov_cnt[1] - c_ov), 16'd16);
        chk("lit_b_done", 16'(fd_cnt[1] - c_fd), 16'd1);
        chk("lit_b_pn", 16'(pn_b), 16'd5);
        send_frame(2, 5, 1'b0, 16'h0, 1'b0, 1'b1, 3);
        idle(1);
        send_frame(1, 0, 1'b0, 16'h0, 1'b0, 1'b1, -1);
        idle(2);

        // Random frames on both instances.
        for (int s = 0; s < 2; s++) begin
            sel    = s;
            nports = (s == 0) ? 4 : 8;
            idle(2);
            for (int f = 0; f < 30; f++) begin
                len    = $urandom_range(0, 3);
                port   = $urandom_range(0, nports - 1);
                flip   = 1'($urandom_range(0, 1));
                stop_b = ($urandom_range(0, 7) != 0);
                rst_at = ((len > 0) && ($urandom_range(0, 9) == 0)) ? $urandom_range(0, len * 8 - 1) : -1;
                send_frame(len, port, 1'b0, 16'h0, flip, stop_b, rst_at);
                if (rst_at < 0 && !stop_b) begin
                    repeat ($urandom_range(0, 3)) put(1'b0, 1'b0);
                    put(1'b1, 1'b0);
                    m_err = 0;
                end
                idle($urandom_range(0, 2));
            end
            idle(3);
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        #1;
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
